// File: rtl/dual_request_queue_if.sv
// dual_request_queue_if: the two producer request channels, their flush controls,
// and the merged memory-side output port of dual_request_queue.
// master = producer/memory side (drives requests, flushes, out_ready);
// slave = queue side (drives stalls, merged output, drop_count).
// Widths normally come from defines.vh; the guards below supply defaults if it is absent.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

interface dual_request_queue_if;
  logic [`ADDRESS_WIDTH-1:0] in_address_1;
  logic [`ID_WIDTH-1:0]      in_id_1;
  logic                      in_valid_1;
  logic                      out_stall_1;
  logic                      flush_1;
  logic [`ID_WIDTH-1:0]      flush_id_1;

  logic [`ADDRESS_WIDTH-1:0] in_address_2;
  logic [`ID_WIDTH-1:0]      in_id_2;
  logic                      in_valid_2;
  logic                      out_stall_2;
  logic                      flush_2;
  logic [`ID_WIDTH-1:0]      flush_id_2;

  logic [`ADDRESS_WIDTH-1:0] out_address;
  logic [`ID_WIDTH-1:0]      out_id;
  logic                      out_channel;
  logic                      out_valid;
  logic                      out_ready;
  logic [7:0]                drop_count;

  modport master (
    output in_address_1, in_id_1, in_valid_1, flush_1, flush_id_1,
    output in_address_2, in_id_2, in_valid_2, flush_2, flush_id_2,
    output out_ready,
    input  out_stall_1, out_stall_2,
    input  out_address, out_id, out_channel, out_valid, drop_count
  );

  modport slave (
    input  in_address_1, in_id_1, in_valid_1, flush_1, flush_id_1,
    input  in_address_2, in_id_2, in_valid_2, flush_2, flush_id_2,
    input  out_ready,
    output out_stall_1, out_stall_2,
    output out_address, out_id, out_channel, out_valid, drop_count
  );
endinterface

// File: rtl/dual_request_queue.sv
// dual_request_queue: two per-channel request FIFOs with flush-by-ID, merged round-robin
//   onto one registered valid/ready output. Ports: clk, reset (async, active-high), bus (slave).
// Latency: 2 edges from acceptance to out_valid when idle; 1 request/cycle aggregate.
// Backpressure: out_stall_n = FIFO n full (registered state only); out_* hold while !out_ready.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module dual_request_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  dual_request_queue_if.slave bus
);
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;
  localparam int DW = $clog2(DEPTH + 2);  // holds up to DEPTH kills plus one dropped push
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Channel-indexed views of the interface (index 0 = channel 1).
  logic [AW-1:0] in_addr  [2];
  logic [IW-1:0] in_id    [2];
  logic          in_vld   [2];
  logic          flush    [2];
  logic [IW-1:0] flush_id [2];

  assign in_addr[0]  = bus.in_address_1;
  assign in_addr[1]  = bus.in_address_2;
  assign in_id[0]    = bus.in_id_1;
  assign in_id[1]    = bus.in_id_2;
  assign in_vld[0]   = bus.in_valid_1;
  assign in_vld[1]   = bus.in_valid_2;
  assign flush[0]    = bus.flush_1;
  assign flush[1]    = bus.flush_2;
  assign flush_id[0] = bus.flush_id_1;
  assign flush_id[1] = bus.flush_id_2;

  // Storage. Invariant: live bits of unoccupied slots are always 0 (cleared on pop),
  // so a live head implies a non-empty FIFO and kills never hit stale slots.
  logic [AW-1:0]    mem_addr [2][DEPTH];
  logic [IW-1:0]    mem_id   [2][DEPTH];
  logic [DEPTH-1:0] mem_live [2];
  logic [PTR_W-1:0] wr_ptr   [2];
  logic [PTR_W-1:0] rd_ptr   [2];
  logic [PTR_W:0]   count    [2];
  logic             rr;  // 0: channel 1 wins the next tie, 1: channel 2

  logic [AW-1:0] out_address_q;
  logic [IW-1:0] out_id_q;
  logic          out_channel_q;
  logic          out_valid_q;
  logic [7:0]    drop_q;

  logic             stall     [2];
  logic             push      [2];
  logic             push_live [2];
  logic             head_dead [2];
  logic             elig      [2];
  logic             grant     [2];
  logic             pop       [2];
  logic [DEPTH-1:0] kill      [2];
  logic [DEPTH-1:0] live_nxt  [2];
  logic [DW-1:0]    drops     [2];
  logic             load_en;
  logic             rr_nxt;
  logic [8:0]       drop_sum;

  always_comb begin
    load_en  = !out_valid_q || bus.out_ready;
    rr_nxt   = rr;
    drop_sum = '0;
    for (int c = 0; c < 2; c++) begin
      stall[c]     = (count[c] == FULL_CNT);
      push[c]      = in_vld[c] && !stall[c];
      push_live[c] = !(flush[c] && (in_id[c] == flush_id[c]));
      drops[c]     = '0;
      for (int i = 0; i < DEPTH; i++) begin
        kill[c][i] = flush[c] && mem_live[c][i] && (mem_id[c][i] == flush_id[c]);
        drops[c]   = drops[c] + DW'(kill[c][i]);
      end
      if (push[c] && !push_live[c]) drops[c] = drops[c] + DW'(1);
      head_dead[c] = (count[c] != '0) && !mem_live[c][rd_ptr[c]];
      // A head being killed this edge is not granted; it becomes a dead head next cycle.
      elig[c]      = mem_live[c][rd_ptr[c]] && !kill[c][rd_ptr[c]];
      grant[c]     = 1'b0;
    end

    if (load_en) begin
      if (elig[0] && elig[1]) begin
        grant[0] = !rr;
        grant[1] = rr;
        rr_nxt   = !rr;
      end else begin
        grant[0] = elig[0];
        grant[1] = elig[1];
      end
    end

    for (int c = 0; c < 2; c++) begin
      pop[c]      = head_dead[c] || grant[c];
      live_nxt[c] = mem_live[c] & ~kill[c];
      if (pop[c])  live_nxt[c][rd_ptr[c]] = 1'b0;
      if (push[c]) live_nxt[c][wr_ptr[c]] = push_live[c];
    end

    drop_sum = {1'b0, drop_q} + 9'(drops[0]) + 9'(drops[1]);
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_addr[c][wr_ptr[c]] <= in_addr[c];
        mem_id[c][wr_ptr[c]]   <= in_id[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        count[c]    <= '0;
        mem_live[c] <= '0;
      end
      rr            <= 1'b0;
      out_address_q <= '0;
      out_id_q      <= '0;
      out_channel_q <= 1'b0;
      out_valid_q   <= 1'b0;
      drop_q        <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        mem_live[c] <= live_nxt[c];
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        count[c] <= count[c] + (PTR_W+1)'(push[c]) - (PTR_W+1)'(pop[c]);
      end
      rr <= rr_nxt;
      if (load_en) begin
        if (grant[0] || grant[1]) begin
          out_valid_q   <= 1'b1;
          out_channel_q <= grant[1];
          out_address_q <= grant[1] ? mem_addr[1][rd_ptr[1]] : mem_addr[0][rd_ptr[0]];
          out_id_q      <= grant[1] ? mem_id[1][rd_ptr[1]]   : mem_id[0][rd_ptr[0]];
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign bus.out_stall_1 = stall[0];
  assign bus.out_stall_2 = stall[1];
  assign bus.out_address = out_address_q;
  assign bus.out_id      = out_id_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_dual_request_queue.sv
// tb_dual_request_queue: table-driven vectors plus hand sequences for stall, flush and reset,
// with a scoreboard of per-channel expected requests checked at every output handshake.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_dual_request_queue;
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  dual_request_queue_if bus();
  dual_request_queue #(.DEPTH(4), .PTR_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
  } req_t;
  req_t q1[$];
  req_t q2[$];
  req_t sb_e;

  typedef struct {
    logic       v1;
    logic [7:0] id1;
    logic       v2;
    logic [7:0] id2;
    logic       rdy;
    logic       e_vld;
    logic [7:0] e_id;
    logic       e_ch;
    logic [1:0] e_stall;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [AW-1:0] addr_of(input logic ch, input logic [IW-1:0] id);
    return AW'(32'hA000_0000) | AW'({ch, 8'h00}) | AW'(id);
  endfunction

  function automatic vec_t row(input logic v1, input logic [7:0] id1, input logic v2,
                               input logic [7:0] id2, input logic ev, input logic [7:0] eid,
                               input logic ech);
    vec_t r;
    r.v1 = v1; r.id1 = id1; r.v2 = v2; r.id2 = id2; r.rdy = 1'b1;
    r.e_vld = ev; r.e_id = eid; r.e_ch = ech; r.e_stall = 2'b00;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [7:0] id);
    if (ch == 1) begin
      bus.in_valid_1 = 1'b1; bus.in_id_1 = IW'(id); bus.in_address_1 = addr_of(1'b0, IW'(id));
    end else begin
      bus.in_valid_2 = 1'b1; bus.in_id_2 = IW'(id); bus.in_address_2 = addr_of(1'b1, IW'(id));
    end
  endtask

  task automatic idle();
    bus.in_valid_1 = 1'b0; bus.in_valid_2 = 1'b0;
    bus.flush_1 = 1'b0; bus.flush_2 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    idle();
    bus.out_ready = 1'b1;
    while ((bus.out_valid || q1.size() != 0 || q2.size() != 0) && n < 40) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= 40), 32'd0);
    check({name, "_sb_left"}, 32'(q1.size() + q2.size()), 32'd0);
  endtask

  // Scoreboard: inputs change only 1 time unit after a rising edge, so values seen at
  // the falling edge are exactly those the next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
      q2.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (!bus.out_channel) begin
          check("sb_ch1_spurious", 32'(q1.size() == 0), 32'd0);
          if (q1.size() != 0) begin
            sb_e = q1.pop_front();
            check("sb_ch1_id", 32'(bus.out_id), 32'(sb_e.id));
            check("sb_ch1_addr", 32'(bus.out_address), 32'(sb_e.addr));
          end
        end else begin
          check("sb_ch2_spurious", 32'(q2.size() == 0), 32'd0);
          if (q2.size() != 0) begin
            sb_e = q2.pop_front();
            check("sb_ch2_id", 32'(bus.out_id), 32'(sb_e.id));
            check("sb_ch2_addr", 32'(bus.out_address), 32'(sb_e.addr));
          end
        end
      end
      if (bus.flush_1)
        for (int i = q1.size() - 1; i >= 0; i--) if (q1[i].id == bus.flush_id_1) q1.delete(i);
      if (bus.flush_2)
        for (int i = q2.size() - 1; i >= 0; i--) if (q2[i].id == bus.flush_id_2) q2.delete(i);
      if (bus.in_valid_1 && !bus.out_stall_1 && !(bus.flush_1 && bus.in_id_1 == bus.flush_id_1))
        q1.push_back('{bus.in_id_1, bus.in_address_1});
      if (bus.in_valid_2 && !bus.out_stall_2 && !(bus.flush_2 && bus.in_id_2 == bus.flush_id_2))
        q2.push_back('{bus.in_id_2, bus.in_address_2});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] id, id_b;
    logic       a, a_b;

    bus.in_address_1 = '0; bus.in_id_1 = '0; bus.flush_id_1 = '0;
    bus.in_address_2 = '0; bus.in_id_2 = '0; bus.flush_id_2 = '0;
    bus.out_ready = 1'b0;
    idle();

    // Single channel stream: first output two edges after acceptance, then in order.
    tbl[0]  = row(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[1]  = row(1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
    tbl[2]  = row(1'b1, 8'h13, 1'b0, 8'h00, 1'b1, 8'h12, 1'b0);
    tbl[3]  = row(1'b1, 8'h14, 1'b0, 8'h00, 1'b1, 8'h13, 1'b0);
    tbl[4]  = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h14, 1'b0);
    tbl[5]  = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    // Both channels: strict alternation starting with channel 1.
    tbl[6]  = row(1'b1, 8'h11, 1'b1, 8'h21, 1'b0, 8'h00, 1'b0);
    tbl[7]  = row(1'b1, 8'h12, 1'b1, 8'h22, 1'b1, 8'h11, 1'b0);
    tbl[8]  = row(1'b1, 8'h13, 1'b1, 8'h23, 1'b1, 8'h21, 1'b1);
    tbl[9]  = row(1'b1, 8'h14, 1'b1, 8'h24, 1'b1, 8'h12, 1'b0);
    tbl[10] = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
    tbl[11] = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h13, 1'b0);
    tbl[12] = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h23, 1'b1);
    tbl[13] = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h14, 1'b0);
    tbl[14] = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h24, 1'b1);
    tbl[15] = row(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset state.
    step(); step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_out_address", 32'(bus.out_address), 32'd0);
    check("rst_stalls", 32'({bus.out_stall_2, bus.out_stall_1}), 32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      bus.in_valid_1 = tbl[k].v1; bus.in_id_1 = IW'(tbl[k].id1);
      bus.in_address_1 = addr_of(1'b0, IW'(tbl[k].id1));
      bus.in_valid_2 = tbl[k].v2; bus.in_id_2 = IW'(tbl[k].id2);
      bus.in_address_2 = addr_of(1'b1, IW'(tbl[k].id2));
      bus.out_ready = tbl[k].rdy;
      step();
      check($sformatf("vec%0d_valid", k), 32'(bus.out_valid), 32'(tbl[k].e_vld));
      check($sformatf("vec%0d_stall", k), 32'({bus.out_stall_2, bus.out_stall_1}),
            32'(tbl[k].e_stall));
      if (tbl[k].e_vld) begin
        check($sformatf("vec%0d_id", k), 32'(bus.out_id), 32'(tbl[k].e_id));
        check($sformatf("vec%0d_channel", k), 32'(bus.out_channel), 32'(tbl[k].e_ch));
      end
    end
    idle();

    // Fill output register + FIFO with out_ready low; 0x16 is held under stall.
    bus.out_ready = 1'b0;
    id = 8'h11;
    for (int c = 0; c < 12 && !(bus.out_stall_1 && id == 8'h16); c++) begin
      send(1, id);
      a = !bus.out_stall_1;
      step();
      if (a) id++;
    end
    check("t2_accepted_before_stall", 32'(id), 32'h16);
    check("t2_stall_full", 32'(bus.out_stall_1), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t2_stall_held", 32'(bus.out_stall_1), 32'd1);
      check("t2_out_stable", 32'(bus.out_id), 32'h11);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && id == 8'h16; c++) begin
      a = !bus.out_stall_1;
      step();
      if (a) id++;
    end
    check("t2_held_accepted", 32'(id), 32'h17);
    drain("t2");

    // Flush a queued ID from the middle of channel 1.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(1, 8'h18 + 8'(k));
      step();
    end
    idle();
    bus.flush_1 = 1'b1; bus.flush_id_1 = IW'(8'h1a);
    step();
    bus.flush_1 = 1'b0;
    check("t4_drop_count", 32'(bus.drop_count), 32'd1);
    drain("t4");

    // Flush matching the request accepted in the same cycle.
    bus.out_ready = 1'b1;
    send(1, 8'h1c);
    bus.flush_1 = 1'b1; bus.flush_id_1 = IW'(8'h1c);
    step();
    idle();
    check("t5_drop_count", 32'(bus.drop_count), 32'd2);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_no_output", 32'(bus.out_valid), 32'd0);
    end
    // A channel-2 flush must not touch channel 1.
    bus.out_ready = 1'b0;
    send(1, 8'h1d); step();
    send(1, 8'h1c); step();
    idle();
    bus.flush_2 = 1'b1; bus.flush_id_2 = IW'(8'h1c);
    step();
    bus.flush_2 = 1'b0;
    check("t5_drop_unchanged", 32'(bus.drop_count), 32'd2);
    drain("t5");

    // Reset while both FIFOs are full and the output register is occupied.
    bus.out_ready = 1'b0;
    id = 8'h41; id_b = 8'h51;
    for (int c = 0; c < 20 && !(bus.out_stall_1 && bus.out_stall_2); c++) begin
      send(1, id); send(2, id_b);
      a = !bus.out_stall_1; a_b = !bus.out_stall_2;
      step();
      if (a) id++;
      if (a_b) id_b++;
    end
    check("t6_full_stalls", 32'({bus.out_stall_2, bus.out_stall_1}), 32'd3);
    check("t6_out_valid_before", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    idle();
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_out_id", 32'(bus.out_id), 32'd0);
    check("t6_rst_out_address", 32'(bus.out_address), 32'd0);
    check("t6_rst_out_channel", 32'(bus.out_channel), 32'd0);
    check("t6_rst_stalls", 32'({bus.out_stall_2, bus.out_stall_1}), 32'd0);
    check("t6_rst_drop_count", 32'(bus.drop_count), 32'd0);
    step(); step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    send(1, 8'h31);
    step();
    idle();
    for (int c = 0; c < 5 && !bus.out_valid; c++) step();
    check("t6_first_valid", 32'(bus.out_valid), 32'd1);
    check("t6_first_id", 32'(bus.out_id), 32'h31);
    check("t6_first_channel", 32'(bus.out_channel), 32'd0);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dual_request_queue.md
Name: dual_request_queue

Overview:
- Downstream consumer of the two-channel request producer: accepts address/ID requests on two independent stall-handshaked input channels.
- Buffers each channel in its own FIFO and applies targeted flushes that cancel queued requests by ID.
- Merges both channels round-robin onto a single registered output port with valid/ready handshake toward the memory side.
- Provides the backpressure (stall) that throttles the producer.

Parameters:
- DEPTH, 4, entries per channel FIFO (power of two, ≥2)
- PTR_W, 2, log2(DEPTH)
- Address and ID widths come from the `ADDRESS_WIDTH` and `ID_WIDTH` defines in defines.vh.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_address_1  input  ADDRESS_WIDTH  channel 1 request address
in_id_1  input  ID_WIDTH  channel 1 request ID
in_valid_1  input  1  channel 1 request valid
out_stall_1  output  1  channel 1 backpressure to producer
flush_1  input  1  channel 1 flush strobe (single cycle)
flush_id_1  input  ID_WIDTH  ID to cancel on channel 1
in_address_2  input  ADDRESS_WIDTH  channel 2 request address
in_id_2  input  ID_WIDTH  channel 2 request ID
in_valid_2  input  1  channel 2 request valid
out_stall_2  output  1  channel 2 backpressure
flush_2  input  1  channel 2 flush strobe
flush_id_2  input  ID_WIDTH  ID to cancel on channel 2
out_address  output  ADDRESS_WIDTH  merged request address
out_id  output  ID_WIDTH  merged request ID
out_channel  output  1  0 = channel 1, 1 = channel 2
out_valid  output  1  merged request valid
out_ready  input  1  downstream accepts out_* this cycle
drop_count  output  8  saturating count of requests cancelled by flush

Behaviour:
- Reset: all outputs 0, FIFOs empty, all entry valid bits 0, round-robin pointer = channel 1, drop_count = 0. Reset mid-operation discards all queued and output-register contents immediately.
- Input handshake, per channel: transfer occurs when in_valid_n && !out_stall_n at a rising edge. The producer holds its outputs while stalled; a held request is accepted exactly once.
- out_stall_n = (count_n == DEPTH), derived from registered state only (no combinational path from inputs). It stays asserted even in a cycle where a pop would free space.
- Each FIFO entry holds {address, id, live}. Enqueue writes live = 1.
- Flush, per channel:
  - When flush_n is high, every entry in FIFO n with live = 1 and id == flush_id_n has live cleared at that edge.
  - If the same-cycle incoming request matches flush_id_n, it is accepted (stall semantics unchanged) but written with live = 0.
  - drop_count increments by the number of entries killed plus any dropped incoming request, saturating at 255.
  - Flush does not affect the output register or the other channel.
- Dead-head removal: each cycle, a channel whose head entry has live = 0 pops it without producing output. The two channels do this independently.
- Output register load: allowed when out_valid == 0 or out_ready == 1.
  - Eligible channels are those with a live head.
  - If both are eligible, grant the channel selected by the round-robin pointer, then set the pointer to the other channel.
  - A lone eligible channel is granted without moving the pointer.
  - The granted head is popped and copied to out_* with out_valid = 1. If nothing is eligible and out_ready is high, out_valid is cleared.
- Latency:
  - A request accepted at edge E0 with both FIFOs otherwise empty and the output free is presented (out_valid = 1) after edge E1, so minimum latency is 2 edges.
  - Throughput is one request per cycle aggregate.
- Ordering: FIFO order is preserved within a channel; between channels, strict alternation when both are eligible.
- Simultaneous push and pop on the same FIFO in one cycle is legal; count is unchanged.
- Pointers wrap modulo DEPTH. Count is PTR_W+1 bits, range 0..DEPTH.
- out_* remain stable while out_valid && !out_ready.

Test Plan:
1. Reset, then channel 1 sends IDs 0x11..0x14 with out_ready = 1 → out_id 0x11..0x14 in order, first one 2 edges after acceptance, out_channel = 0, out_stall_1 never high.
2. out_ready = 0, channel 1 streams continuously → 1 request fills the output register and 4 fill the FIFO, then out_stall_1 = 1. The producer holds ID 0x16; after out_ready goes to 1, 0x16 is emitted exactly once, with no duplicates or gaps.
3. Both channels send continuously with out_ready = 1 → out_channel alternates 0,1,0,1; out_id alternates 0x1n/0x2n.
4. Queue 0x18, 0x19, 0x1a, 0x1b on channel 1 with out_ready = 0, then pulse flush_1 with flush_id_1 = 0x1a → outputs 0x18, 0x19, 0x1b only; drop_count = 1.
5. Flush with flush_id_1 = 0x1c in the same cycle that 0x1c is accepted → 0x1c never appears on out; drop_count increments by 1. A flush_2 for the same ID leaves channel 1 untouched.
6. Assert reset while both FIFOs are full and out_valid = 1 → all outputs 0 immediately; after release, the first output is a newly accepted request.
